// File: rtl/encoder_line_decoder.sv
// Registered one-hot regenerator for the 2-bit priority link: 11->a, 10->b, 01->c, 00->none_o pulse.
// Optional per-line acceptance counters are compiled in with `define DECODER_COUNT_EN.
module encoder_line_decoder #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] code_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       none_o,
    output logic       busy
`ifdef DECODER_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c
`endif
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    if (HOLD < 1 || HOLD > 255 || CNT_W < 1) begin : g_bad_param
        $error("encoder_line_decoder: HOLD must be 1..255 and CNT_W >= 1");
    end

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] line_q, line_d;   // {a, b, c}
    logic       none_q, none_d;
    logic       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            none_q  <= none_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        none_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (code_in == 2'b00) begin
                        none_d = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_M1;
                        case (code_in)
                            2'b11:   line_d = 3'b100;
                            2'b10:   line_d = 3'b010;
                            default: line_d = 3'b001;
                        endcase
                    end
                end
            end
            default: begin
                // Counter reaching zero means this is the last held cycle.
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    line_d  = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q == S_HOLD);
    end

    assign accept      = in_valid && in_ready;
    assign {a, b, c}   = line_q;
    assign none_o      = none_q;

`ifdef DECODER_COUNT_EN
    logic [CNT_W-1:0] evt_q [3];   // index 0/1/2 counts codes 11/10/01

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) evt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (accept && code_in == 2'(3 - i) && evt_q[i] != '1)
                    evt_q[i] <= evt_q[i] + 1'b1;
            end
        end
    end

    assign cnt_a = evt_q[0];
    assign cnt_b = evt_q[1];
    assign cnt_c = evt_q[2];
`endif

endmodule

// File: doc/encoder_line_decoder.md
# encoder_line_decoder

Registered inverse of the team's 3-input priority encoder: accepts a 2-bit priority code over a valid/ready handshake and drives the corresponding one-hot request line (a, b or c) for a programmable number of cycles. It sits at the receiving end of the encoded link and regenerates the original request lines for downstream logic. Code mapping is fixed: 2'b11 → a, 2'b10 → b, 2'b01 → c, 2'b00 → no request.

## Interface
- HOLD, default 4: cycles a decoded line stays asserted; legal range 1..255.
- CNT_W, default 8: width of the per-line event counters (only with DECODER_COUNT_EN).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- code_in  input  2  encoded request; sampled only on handshake.
- in_valid  input  1  code_in is valid.
- in_ready  output  1  block can accept a code this cycle.
- a  output  1  decoded line for code 2'b11, registered.
- b  output  1  decoded line for code 2'b10, registered.
- c  output  1  decoded line for code 2'b01, registered.
- none_o  output  1  one-cycle pulse when code 2'b00 is accepted.
- busy  output  1  high while a line is being held.
- cnt_a, cnt_b, cnt_c  output  CNT_W  per-line acceptance counters (present only with DECODER_COUNT_EN).

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, HOLD.
- IDLE: in_ready = 1, busy = 0, a = b = c = 0.
- Handshake: a code is accepted when in_valid && in_ready at a rising edge.
- Accepting a code in {11, 10, 01} moves to HOLD, loads the down-counter with HOLD-1, and sets the matching line register. Exactly one of a/b/c is set.
- Accepting 2'b00 stays in IDLE, pulses none_o for one cycle, and leaves a/b/c untouched.
- HOLD: in_ready = 0, busy = 1; the counter decrements each cycle. When the counter is 0, the next edge returns to IDLE and clears a/b/c.
- in_valid during HOLD is ignored; the source must hold code_in/in_valid until it sees in_ready.
- in_ready and busy decode directly from the state register; there is no combinational path from in_valid to in_ready.
- Reset mid-HOLD: all outputs drop asynchronously to their reset values and the state is IDLE.
- Reset values: in_ready = 1, busy = 0, a = b = c = 0, none_o = 0, counters = 0, state = IDLE.

## Timing
- Code accepted at edge T: the line is high for cycles T+1 .. T+HOLD, which is exactly HOLD cycles. busy follows the same window.
- in_ready is low during T+1 .. T+HOLD and high again at T+HOLD+1. Maximum throughput is one code per HOLD+1 cycles.
- HOLD = 1: the line is high for the single cycle T+1, and in_ready returns at T+2.
- none_o: accepted at T, high only during T+1. Back-to-back 2'b00 codes are accepted every cycle.
- Latency from acceptance to line assertion is 1 cycle.

## Configuration
- Macro: DECODER_COUNT_EN.
- Defined: the cnt_a, cnt_b and cnt_c ports exist. Each counter increments by 1 on acceptance of its code and saturates at 2^CNT_W-1 (no wrap). Counters clear only on rst. 2'b00 is not counted.
- Undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then send code 2'b11 with HOLD=4 → a high for exactly 4 cycles starting 1 cycle after the handshake; b = c = 0; in_ready low for those 4 cycles.
- Send 10 then 01 with in_valid held continuously → b pulse of HOLD cycles, then 01 accepted the cycle in_ready returns, then a c pulse of HOLD cycles; the two lines are never high together.
- Send 2'b00 three cycles in a row → three consecutive none_o pulses; a/b/c stay 0; busy stays 0.
- Assert rst asynchronously mid-HOLD (2 cycles into an a pulse) → a drops without waiting for a clock edge; in_ready = 1 after reset; the next code decodes normally.
- Build with HOLD=1: code 01 → c high for 1 cycle; in_ready low for 1 cycle.
- With DECODER_COUNT_EN and CNT_W=2: accept code 11 five times → cnt_a = 3 (saturated); cnt_b = cnt_c = 0.
